// File: rtl/ipacket_issue_queue_pkg.sv
// Shared LC-3b types for the decode/issue stage.
//   lc3b_word    : 16-bit machine word
//   lc3b_reg     : 3-bit register index
//   lc3b_opcode  : instruction opcode, inst[15:12]
//   lc3b_ipacket : decoded instruction packet handed to the issue stage
//   ipq_entry_t  : one queued fetch result {inst, pc}
package ipacket_issue_queue_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDW  = 4'b0110,
    OP_STW  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  // Link register written by JSR/JSRR and TRAP.
  localparam lc3b_reg LINK_REG = 3'd7;

  // Register fields are zero when the corresponding enable is clear.
  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_word   inst;
    lc3b_word   pc;
    lc3b_reg    dr_sr;        // destination, or store-data source when sr2_mux_sel
    lc3b_reg    sr1;
    lc3b_reg    sr2;
    logic       opA;          // sr1 is read
    logic       opB;          // sr2 is read
    logic       sr2_mux_sel;  // dr_sr is read as store data
    logic       load_regfile; // dr_sr is written
    logic       load_cc;
  } lc3b_ipacket;

  typedef struct packed {
    lc3b_word inst;
    lc3b_word pc;
  } ipq_entry_t;

endpackage

// File: rtl/ipacket_issue_queue_decode_table.sv
// ipacket_decode_table: combinational opcode table, inst/pc -> lc3b_ipacket.
// The pc field is passed through unchanged; any pc offset is applied by the caller.
//   i_inst     : instruction word
//   i_pc       : pc of the instruction
//   o_ipacket  : decoded packet; unknown opcodes yield an all-default NOP packet
module ipacket_decode_table
  import ipacket_issue_queue_pkg::*;
(
  input  lc3b_word    i_inst,
  input  lc3b_word    i_pc,
  output lc3b_ipacket o_ipacket
);

  lc3b_opcode w_op;
  assign w_op = lc3b_opcode'(i_inst[15:12]);

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    o_ipacket        = '0;
    o_ipacket.opcode = w_op;
    o_ipacket.inst   = i_inst;
    o_ipacket.pc     = i_pc;
    case (w_op)
      OP_ADD, OP_AND: begin
        o_ipacket.dr_sr        = i_inst[11:9];
        o_ipacket.sr1          = i_inst[8:6];
        o_ipacket.opA          = 1'b1;
        o_ipacket.load_regfile = 1'b1;
        o_ipacket.load_cc      = 1'b1;
        // bit 5 selects the immediate form, which has no second register source
        if (!i_inst[5]) begin
          o_ipacket.sr2 = i_inst[2:0];
          o_ipacket.opB = 1'b1;
        end
      end
      OP_NOT, OP_SHF, OP_LDB, OP_LDW, OP_LDI: begin
        o_ipacket.dr_sr        = i_inst[11:9];
        o_ipacket.sr1          = i_inst[8:6];
        o_ipacket.opA          = 1'b1;
        o_ipacket.load_regfile = 1'b1;
        o_ipacket.load_cc      = 1'b1;
      end
      OP_LEA: begin
        o_ipacket.dr_sr        = i_inst[11:9];
        o_ipacket.load_regfile = 1'b1;
      end
      OP_STB, OP_STW, OP_STI: begin
        o_ipacket.dr_sr       = i_inst[11:9];
        o_ipacket.sr1         = i_inst[8:6];
        o_ipacket.opA         = 1'b1;
        o_ipacket.sr2_mux_sel = 1'b1;
      end
      OP_JMP: begin
        o_ipacket.sr1 = i_inst[8:6];
        o_ipacket.opA = 1'b1;
      end
      OP_JSR: begin
        o_ipacket.dr_sr        = LINK_REG;
        o_ipacket.load_regfile = 1'b1;
        // JSRR (bit 11 clear) jumps through a base register
        if (!i_inst[11]) begin
          o_ipacket.sr1 = i_inst[8:6];
          o_ipacket.opA = 1'b1;
        end
      end
      OP_TRAP: begin
        o_ipacket.dr_sr        = LINK_REG;
        o_ipacket.load_regfile = 1'b1;
      end
      default: ; // BR, RTI: no register traffic
    endcase
  end

endmodule

// File: rtl/ipacket_issue_queue.sv
// ipacket_issue_queue: buffered decode/issue stage for the LC-3b pipeline.
// Fetched {inst, pc} pairs are queued; the head is decoded and issued once no
// source register has an outstanding writer (per-register pending counters).
//   clk, reset_n            : clock, synchronous active-low reset
//   in_valid/in_ready       : fetch handshake, in_inst/in_pc payload
//   out_valid/out_ready     : issue handshake, out_ipacket payload (pc + PC_INC)
//   wb_valid/wb_dr          : retirement of one issued register writer
//   flush                   : discard all queued entries (counters kept)
//   occupancy               : entries held
//   sb_err                  : sticky, retirement seen for a register with no writer
module ipacket_issue_queue
  import ipacket_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SB_CNT_W = 2,
  parameter int unsigned PC_INC   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  lc3b_word                 in_inst,
  input  lc3b_word                 in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output lc3b_ipacket              out_ipacket,
  input  logic                     wb_valid,
  input  lc3b_reg                  wb_dr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     sb_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned NREG = 8;
  localparam logic [SB_CNT_W-1:0] SB_MAX = '1;

  ipq_entry_t          r_fifo [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_occ;
  logic [SB_CNT_W-1:0] r_sb [NREG];
  logic                r_sb_err;

  ipq_entry_t          w_head;
  lc3b_ipacket         w_dec;
  lc3b_ipacket         w_pkt;
  logic                w_full;
  logic                w_hazard;
  logic                w_push;
  logic                w_issue;
  logic [NREG-1:0]     w_sb_inc;
  logic [NREG-1:0]     w_sb_dec;
  logic                w_underflow;

  assign w_head = r_fifo[r_rd_ptr];

  ipacket_decode_table u_decode (
    .i_inst    (w_head.inst),
    .i_pc      (w_head.pc),
    .o_ipacket (w_dec)
  );

  always_comb begin
    w_pkt    = w_dec;
    w_pkt.pc = w_dec.pc + 16'(PC_INC);
  end

  // RAW on any read source, or no room left in the destination's counter.
  always_comb begin
    w_hazard = 1'b0;
    if (w_pkt.opA && r_sb[w_pkt.sr1] != '0)                w_hazard = 1'b1;
    if (w_pkt.opB && r_sb[w_pkt.sr2] != '0)                w_hazard = 1'b1;
    if (w_pkt.sr2_mux_sel && r_sb[w_pkt.dr_sr] != '0)      w_hazard = 1'b1;
    if (w_pkt.load_regfile && r_sb[w_pkt.dr_sr] == SB_MAX) w_hazard = 1'b1;
  end

  // A full queue refuses a push even when the head leaves in the same cycle.
  assign w_full    = (r_occ == (AW+1)'(DEPTH));
  assign in_ready  = reset_n && !flush && !w_full;
  assign out_valid = reset_n && (r_occ != '0) && !w_hazard && !flush;
  assign w_push    = in_valid && in_ready;
  assign w_issue   = out_valid && out_ready;

  assign out_ipacket = w_pkt;
  assign occupancy   = r_occ;
  assign sb_err      = r_sb_err;

  always_comb begin
    w_sb_inc    = '0;
    w_sb_dec    = '0;
    w_underflow = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_sb_inc[r] = w_issue && w_pkt.load_regfile && (w_pkt.dr_sr == lc3b_reg'(r));
      w_sb_dec[r] = wb_valid && (wb_dr == lc3b_reg'(r));
      // a simultaneous issue to the same register cancels the retirement
      if (w_sb_dec[r] && !w_sb_inc[r] && r_sb[r] == '0) w_underflow = 1'b1;
    end
  end

  // NOTE: the entry storage carries no reset; a slot is only read after a push wrote it.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ipq_entry_t'{inst: in_inst, pc: in_pc};
  end

  // NOTE: all state below uses non-blocking assignment so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_sb_err <= 1'b0;
      for (int r = 0; r < NREG; r++) r_sb[r] <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push)  r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_issue})
          2'b10:   r_occ <= r_occ + (AW+1)'(1);
          2'b01:   r_occ <= r_occ - (AW+1)'(1);
          default: ;
        endcase
      end
      // Counters survive a flush: downstream still retires squashed writers.
      for (int r = 0; r < NREG; r++) begin
        if (w_sb_inc[r] && !w_sb_dec[r])
          r_sb[r] <= r_sb[r] + SB_CNT_W'(1);
        else if (w_sb_dec[r] && !w_sb_inc[r] && r_sb[r] != '0)
          r_sb[r] <= r_sb[r] - SB_CNT_W'(1);
      end
      if (w_underflow) r_sb_err <= 1'b1;
    end
  end

endmodule
